// File: rtl/imem_loader.sv
// Instruction-memory responder for the fetch stage.
// Holds the program store, fills it from a valid/ready boot-load stream,
// and gates the CPU through cpu_en until a complete program is present.
module imem_loader #(
  parameter int          ADDR_W   = 10,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic [31:0]       insn,
  output logic              cpu_en,
  output logic [ADDR_W:0]   load_cnt,
  output logic              misalign_err,
  output logic              range_err,
  input  logic              err_clr
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_RUN
  } state_t;

  state_t            r_state;
  logic              r_cpu_en;
  logic [ADDR_W:0]   r_load_cnt;
  logic              r_misalign_err;
  logic              r_range_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_beat;
  logic              w_misalign;
  logic              w_range;
  logic              w_fetch_ok;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_wr_idx;

  // Loader handshake: the store only accepts words while loading.
  assign ld_ready = (r_state == S_LOAD);
  assign w_beat   = ld_valid && ld_ready;
  // The counter never reaches DEPTH while in LOAD, so the low bits are the word index.
  assign w_wr_idx = r_load_cnt[ADDR_W-1:0];

  // Fetch decode: word index plus misalignment / out-of-range qualifiers.
  assign w_rd_idx   = fetch_pc[ADDR_W+1:2];
  assign w_misalign = |fetch_pc[1:0];
  assign w_range    = |fetch_pc[PC_W-1:ADDR_W+2];
  assign w_fetch_ok = r_cpu_en && !w_misalign && !w_range;
  assign insn       = w_fetch_ok ? r_mem[w_rd_idx] : NOP_INSN;

  assign cpu_en       = r_cpu_en;
  assign load_cnt     = r_load_cnt;
  assign misalign_err = r_misalign_err;
  assign range_err    = r_range_err;

  // Program store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_mem[w_wr_idx] <= ld_data;
    end
  end

  // Load/run sequencer with registered cpu_en and word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cpu_en   <= 1'b0;
      r_load_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cpu_en <= 1'b0;
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_load_cnt <= '0;
          end
        end
        S_LOAD: begin
          r_cpu_en <= 1'b0;
          if (w_beat) begin
            r_load_cnt <= r_load_cnt + CNT_ONE;
            // Leave on the marked last word or once the final slot is filled.
            if (ld_last || (r_load_cnt == LAST_IDX)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_cpu_en <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_load_cnt <= '0;
            r_cpu_en   <= 1'b0;
          end else begin
            r_cpu_en <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cpu_en <= 1'b0;
        end
      endcase
    end
  end

  // Sticky fetch error flags; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign_err <= 1'b0;
      r_range_err    <= 1'b0;
    end else begin
      if (r_cpu_en && w_misalign) begin
        r_misalign_err <= 1'b1;
      end else if (err_clr) begin
        r_misalign_err <= 1'b0;
      end
      if (r_cpu_en && w_range) begin
        r_range_err <= 1'b1;
      end else if (err_clr) begin
        r_range_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: load, gapped load, full fill,
// fetch error flags, reload and reset during load.
module tb_imem_loader;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              reset;
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic [31:0]       fetch_pc;
  logic [31:0]       insn;
  logic              cpu_en;
  logic [ADDR_W:0]   load_cnt;
  logic              misalign_err;
  logic              range_err;
  logic              err_clr;

  imem_loader #(.ADDR_W(ADDR_W), .PC_W(32), .NOP_INSN(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .fetch_pc     (fetch_pc),
    .insn         (insn),
    .cpu_en       (cpu_en),
    .load_cnt     (load_cnt),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic        exp_en;
  int          exp_cnt;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_insn(input logic [31:0] pc);
    logic [31:0] hi;
    hi = pc >> (ADDR_W + 2);
    if (!exp_en || (pc[1:0] != 2'b00) || (hi != 32'd0)) return NOP;
    return model_mem[pc[ADDR_W+1:2]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch address, queue the model's answer, then compare the DUT's.
  task automatic fetch_check(input string tag, input logic [31:0] pc);
    exp_t e;
    exp_t got;
    fetch_pc = pc;
    e.tag = tag;
    e.val = model_insn(pc);
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check(got.tag, insn, got.val);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    exp_cnt  = 0;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #1;
    check("ld_ready_in_load", {31'd0, ld_ready}, 32'd1);
    model_mem[exp_cnt[ADDR_W-1:0]] = data;
    exp_cnt++;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_en   = 1'b0;
    exp_cnt  = 0;
    reset    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    fetch_pc = '0;
    err_clr  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_load_cnt", 32'(load_cnt), 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_range", {31'd0, range_err}, 32'd0);
    fetch_check("rst_insn_nop", 32'h0);
    reset = 1'b1;
    tick();

    // Basic 4-word load
    pulse_start();
    send_word(32'h0050_0093, 1'b0);
    send_word(32'h0010_8113, 1'b0);
    send_word(32'h0020_81B3, 1'b0);
    send_word(32'h0000_006F, 1'b1);
    check("t1_done_ready", {31'd0, ld_ready}, 32'd0);
    check("t1_done_cpu_en", {31'd0, cpu_en}, 32'd0);
    fetch_check("t1_done_insn_nop", 32'h8);
    tick();
    exp_en = 1'b1;
    check("t1_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t1_load_cnt", 32'(load_cnt), 32'd4);
    fetch_check("t1_insn_8", 32'h8);
    fetch_check("t1_insn_0", 32'h0);
    fetch_check("t1_insn_c", 32'hC);

    // Reload with a gapped loader and a stray ld_start mid-load
    fetch_pc = 32'h0;
    pulse_start();
    exp_en = 1'b0;
    check("t2_cpu_en_fall", {31'd0, cpu_en}, 32'd0);
    fetch_check("t2_load_nop", 32'h0);
    for (int w = 0; w < 3; w++) begin
      tick();
      if (w == 1) begin
        ld_start = 1'b1;
      end
      tick();
      ld_start = 1'b0;
      send_word(32'hA000_0000 + 32'(w), (w == 2));
      if (w < 2) begin
        check("t2_cnt_mid", 32'(load_cnt), 32'(w + 1));
      end
    end
    tick();
    exp_en = 1'b1;
    check("t2_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t2_load_cnt", 32'(load_cnt), 32'd3);
    fetch_check("t2_insn_0", 32'h0);
    fetch_check("t2_insn_4", 32'h4);
    fetch_check("t2_insn_8", 32'h8);
    fetch_check("t2_stale_c", 32'hC);

    // Error flags
    fetch_check("t3_misal_nop", 32'h2);
    tick();
    fetch_pc = 32'h0;
    check("t3_misal_set", {31'd0, misalign_err}, 32'd1);
    check("t3_misal_rng", {31'd0, range_err}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_clr_misal", {31'd0, misalign_err}, 32'd0);
    fetch_check("t3_range_nop", 32'(DEPTH * 4));
    tick();
    fetch_pc = 32'h0;
    check("t3_range_set", {31'd0, range_err}, 32'd1);
    check("t3_range_mis", {31'd0, misalign_err}, 32'd0);
    fetch_check("t3_both_nop", 32'(DEPTH * 4 + 1));
    tick();
    check("t3_both_mis", {31'd0, misalign_err}, 32'd1);
    check("t3_both_rng", {31'd0, range_err}, 32'd1);
    fetch_pc = 32'h2;
    err_clr  = 1'b1;
    tick();
    err_clr  = 1'b0;
    fetch_pc = 32'h0;
    check("t3_setwins_mis", {31'd0, misalign_err}, 32'd1);
    check("t3_clr_rng", {31'd0, range_err}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_clr_all", {30'd0, misalign_err, range_err}, 32'd0);

    // Full fill without ld_last
    pulse_start();
    exp_en = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      send_word($urandom, 1'b0);
    end
    check("t4_done_ready", {31'd0, ld_ready}, 32'd0);
    check("t4_load_cnt", 32'(load_cnt), 32'(DEPTH));
    check("t4_done_cpu_en", {31'd0, cpu_en}, 32'd0);
    tick();
    exp_en = 1'b1;
    check("t4_cpu_en", {31'd0, cpu_en}, 32'd1);
    fetch_check("t4_last_word", 32'((DEPTH - 1) * 4));
    fetch_check("t4_first_word", 32'h0);
    fetch_check("t4_mid_word", 32'h200);

    // Reload a 2-word program; errors frozen while cpu_en=0
    fetch_pc = 32'h0;
    pulse_start();
    exp_en = 1'b0;
    check("t5_cpu_en_fall", {31'd0, cpu_en}, 32'd0);
    fetch_pc = 32'h2;
    tick();
    check("t5_no_err_load", {31'd0, misalign_err}, 32'd0);
    fetch_check("t5_load_nop", 32'h0);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'h9ABC_DEF0, 1'b1);
    fetch_check("t5_done_nop", 32'h4);
    tick();
    exp_en = 1'b1;
    check("t5_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t5_load_cnt", 32'(load_cnt), 32'd2);
    fetch_check("t5_insn_0", 32'h0);
    fetch_check("t5_insn_4", 32'h4);
    fetch_check("t5_stale_8", 32'h8);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    ld_valid = 1'b0;
    check("t5_run_ready", {31'd0, ld_ready}, 32'd0);
    check("t5_run_cnt", 32'(load_cnt), 32'd2);
    fetch_check("t5_run_nowrite", 32'h0);

    // Reset in the middle of a load
    fetch_pc = 32'h0;
    pulse_start();
    exp_en = 1'b0;
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("t6_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("t6_rst_cnt", 32'(load_cnt), 32'd0);
    tick();
    reset = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'h5555_5555;
    tick();
    tick();
    ld_valid = 1'b0;
    check("t6_idle_ready", {31'd0, ld_ready}, 32'd0);
    check("t6_idle_cnt", 32'(load_cnt), 32'd0);
    pulse_start();
    send_word(32'h3333_3333, 1'b1);
    tick();
    exp_en = 1'b1;
    check("t6_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("t6_load_cnt", 32'(load_cnt), 32'd1);
    fetch_check("t6_insn_0", 32'h0);
    fetch_check("t6_stale_4", 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
